decompressor: RTL and testbench

- Read-side counterpart of the outmap compressor.
- Fetches 64-bit compressed packets from memory, expands their zero-run/value groups back into a byte stream, and presents up to 16 bytes per cycle to the inmap consumer.
- Sits between the memory read port and the PE input-map loader. The consumer reports how many bytes it took each cycle, mirroring the compressor's valid/taken handshake.

---
 rtl/decompressor_pkg.sv | 27 ++
 rtl/decomp_buffer.sv | 65 ++++++
 rtl/decompressor.sv | 136 +++++++++++++
 tb/tb_decompressor.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/decompressor_pkg.sv
// Shared types and packet-layout constants for the packet decompressor.
// A packet is a flag bit, a 3-bit group count and five 12-bit zero-run/value groups.
package decompressor_pkg;

    localparam int PKT_W      = 64;
    localparam int MAX_GROUPS = 5;
    localparam int GRP_W      = 12;
    localparam int FLAG_BIT   = 63;
    localparam int CNT_LSB    = 60;

    typedef struct packed {
        logic [7:0] val;
        logic [3:0] zero;
    } compress_unit_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    // Group counts above the five physical slots are clamped.
    function automatic logic [2:0] clamp_groups(input logic [2:0] g);
        return (g > 3'(MAX_GROUPS)) ? 3'(MAX_GROUPS) : g;
    endfunction

endpackage

// File: rtl/decomp_buffer.sv
// Byte staging buffer: each cycle drops taken_num bytes from the front and
// appends wr_len bytes at the new tail. Lane 0 is always the oldest byte.
module decomp_buffer
    import decompressor_pkg::*;
#(
    parameter int BUF_BYTES = 32,
    parameter int OUT_LANES = 16
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [4:0]                           taken_num,
    input  logic [4:0]                           wr_len,
    input  logic [15:0][7:0]                     wr_bytes,
    output logic [$clog2(BUF_BYTES+1)-1:0]       fill,
    output logic [OUT_LANES-1:0][7:0]            out_data,
    output logic [4:0]                           out_valid_num
);

    localparam int FW = $clog2(BUF_BYTES + 1);

    logic [BUF_BYTES-1:0][7:0] mem_reg, mem_next, shifted;
    logic [FW-1:0]             fill_reg, fill_next, base, off;
    logic [4:0]                valid_reg;

    always_comb begin
        base      = (FW'(taken_num) >= fill_reg) ? '0 : fill_reg - FW'(taken_num);
        fill_next = base + FW'(wr_len);
        shifted   = mem_reg >> {taken_num, 3'b000};
        off       = '0;
        // Bytes past the new fill are kept at zero so idle lanes read as 0.
        for (int i = 0; i < BUF_BYTES; i++) begin
            mem_next[i] = 8'h00;
            off         = FW'(i) - base;
            if (i < int'(base))
                mem_next[i] = shifted[i];
            else if (i < int'(fill_next))
                mem_next[i] = wr_bytes[off[3:0]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_reg   <= '0;
            fill_reg  <= '0;
            valid_reg <= '0;
        end else begin
            mem_reg   <= mem_next;
            fill_reg  <= fill_next;
            valid_reg <= (fill_next > FW'(OUT_LANES)) ? 5'(OUT_LANES) : 5'(fill_next);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < OUT_LANES; gi++) begin : g_lane
            assign out_data[gi] = mem_reg[gi];
        end
    endgenerate

    assign fill          = fill_reg;
    assign out_valid_num = valid_reg;

    taken_le_valid: assert property (@(posedge clk) disable iff (!rst_n) taken_num <= valid_reg);

endmodule

// File: rtl/decompressor.sv
// Fetches compressed packets, expands one zero-run/value group per cycle into
// the staging buffer and presents up to 16 bytes per cycle to the consumer.
module decompressor
    import decompressor_pkg::*;
#(
    parameter int OUT_LANES = 16,
    parameter int BUF_BYTES = 32,
    parameter int CNT_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [CNT_W-1:0]      pkt_count,
    output logic                  mem_req,
    input  logic                  mem_ack,
    input  logic [PKT_W-1:0]      mem_data,
    output logic [15:0][7:0]      inmap_data,
    output logic [4:0]            inmap_data_valid_num,
    input  logic [4:0]            taken_num,
    output logic                  busy,
    output logic                  done,
    output logic                  fmt_err
);

    localparam int FW = $clog2(BUF_BYTES + 1);

    state_t             state_reg;
    logic [CNT_W-1:0]   pkts_rem_reg;
    logic [PKT_W-1:0]   pkt_reg;
    logic               pkt_vld_reg;
    logic [2:0]         grp_idx_reg;
    logic               busy_reg, done_reg, fmt_err_reg;

    compress_unit_t     grp_arr [MAX_GROUPS];
    compress_unit_t     cur;
    logic [2:0]         g_eff;
    logic [FW-1:0]      fill, base;
    logic               space_ok, appending, is_last, retire, valueless, accept;
    logic [4:0]         wr_len;
    logic [15:0][7:0]   wr_bytes;

    genvar gi;
    generate
        for (gi = 0; gi < MAX_GROUPS; gi++) begin : g_grp
            assign grp_arr[gi] = pkt_reg[gi*GRP_W +: GRP_W];
        end
        for (gi = 0; gi < 16; gi++) begin : g_wr
            assign wr_bytes[gi] = (4'(gi) < cur.zero) ? 8'h00 : cur.val;
        end
    endgenerate

    always_comb begin
        cur = grp_arr[0];
        for (int k = 0; k < MAX_GROUPS; k++)
            if (grp_idx_reg == 3'(k)) cur = grp_arr[k];
        g_eff     = clamp_groups(pkt_reg[CNT_LSB +: 3]);
        base      = (FW'(taken_num) >= fill) ? '0 : fill - FW'(taken_num);
        // A whole 16-byte group must fit behind the post-shift tail.
        space_ok  = base <= FW'(BUF_BYTES - 16);
        appending = (state_reg == RUN) && pkt_vld_reg && space_ok;
        is_last   = (g_eff == 3'd0) || (grp_idx_reg == g_eff - 3'd1);
        retire    = appending && is_last;
        valueless = is_last && !pkt_reg[FLAG_BIT];
        wr_len    = 5'(cur.zero) + (valueless ? 5'd0 : 5'd1);
        if (!appending || g_eff == 3'd0)
            wr_len = '0;
        mem_req   = (state_reg == RUN) && (pkts_rem_reg != '0) && (!pkt_vld_reg || retire);
        accept    = mem_req && mem_ack;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            pkts_rem_reg <= '0;
            pkt_reg      <= '0;
            pkt_vld_reg  <= 1'b0;
            grp_idx_reg  <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            fmt_err_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            unique case (state_reg)
                IDLE: if (start) begin
                    fmt_err_reg <= 1'b0;
                    if (pkt_count != '0) begin
                        state_reg    <= RUN;
                        busy_reg     <= 1'b1;
                        pkts_rem_reg <= pkt_count;
                    end else begin
                        done_reg <= 1'b1;
                    end
                end
                RUN: if (retire && pkts_rem_reg == '0) state_reg <= DRAIN;
                DRAIN: if (base == '0) begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b1;
                end
                default: state_reg <= IDLE;
            endcase

            if (accept) begin
                pkt_reg      <= mem_data;
                pkt_vld_reg  <= 1'b1;
                grp_idx_reg  <= '0;
                pkts_rem_reg <= pkts_rem_reg - 1'b1;
                if (mem_data[CNT_LSB +: 3] > 3'(MAX_GROUPS)) fmt_err_reg <= 1'b1;
            end else if (retire) begin
                pkt_vld_reg <= 1'b0;
                grp_idx_reg <= '0;
            end else if (appending) begin
                grp_idx_reg <= grp_idx_reg + 3'd1;
            end
        end
    end

    decomp_buffer #(
        .BUF_BYTES (BUF_BYTES),
        .OUT_LANES (OUT_LANES)
    ) u_buf (
        .clk           (clk),
        .rst_n         (rst_n),
        .taken_num     (taken_num),
        .wr_len        (wr_len),
        .wr_bytes      (wr_bytes),
        .fill          (fill),
        .out_data      (inmap_data),
        .out_valid_num (inmap_data_valid_num)
    );

    assign busy    = busy_reg;
    assign done    = done_reg;
    assign fmt_err = fmt_err_reg;

endmodule

// File: tb/tb_decompressor.sv
// Bench for decompressor: directed table cases, hand sequences for latency,
// zero-count start and reset, then random packets against a byte-stream model.
module tb_decompressor;

    logic             clk = 1'b0;
    logic             rst_n, start, mem_ack, mem_req, busy, done, fmt_err;
    logic [15:0]      pkt_count;
    logic [63:0]      mem_data;
    logic [15:0][7:0] inmap_data;
    logic [4:0]       valid_num, taken_num;

    int tests = 0;
    int fails = 0;

    byte unsigned golden[$];
    logic [63:0]  pk[$];

    typedef struct {
        int          n;
        logic [63:0] p0, p1, p2;
        int          delay;
        int          mode;      // 0 take all, 1 random take, 2 hold then take all
        bit          exp_err;
        int          exp_bytes; // -1: not fixed by hand
        int          exp_peak;  // -1: not checked
    } case_t;

    always #5 clk = ~clk;

    decompressor dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .start                (start),
        .pkt_count            (pkt_count),
        .mem_req              (mem_req),
        .mem_ack              (mem_ack),
        .mem_data             (mem_data),
        .inmap_data           (inmap_data),
        .inmap_data_valid_num (valid_num),
        .taken_num            (taken_num),
        .busy                 (busy),
        .done                 (done),
        .fmt_err              (fmt_err)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference expansion straight from the packet format rules.
    function automatic void expand(input logic [63:0] p);
        int g;
        int z;
        byte unsigned v;
        g = int'(p[62:60]);
        if (g > 5) g = 5;
        for (int k = 0; k < g; k++) begin
            z = int'(p[12*k +: 4]);
            v = p[12*k+4 +: 8];
            for (int i = 0; i < z; i++) golden.push_back(8'h00);
            if (k < g - 1 || p[63]) golden.push_back(v);
        end
    endfunction

    task automatic run_case(input int id, input case_t c);
        int  pos, pi, waitc, cyc, peak, take;
        bit  seen_done, ok;
        golden.delete();
        pk.delete();
        pk.push_back(c.p0);
        if (c.n > 1) pk.push_back(c.p1);
        if (c.n > 2) pk.push_back(c.p2);
        foreach (pk[i]) expand(pk[i]);
        if (c.exp_bytes >= 0) chk("golden_len", golden.size(), c.exp_bytes);
        pos = 0; pi = 0; waitc = 0; cyc = 0; peak = 0; seen_done = 0;
        start = 1'b1;
        pkt_count = 16'(c.n);
        @(posedge clk); #1;
        start = 1'b0;
        while (cyc < 3000) begin
            if (done) begin
                seen_done = 1;
                break;
            end
            if (int'(valid_num) > peak) peak = int'(valid_num);
            if (valid_num != 0) begin
                ok = 1;
                for (int j = 0; j < int'(valid_num); j++)
                    if (pos + j >= golden.size() || inmap_data[j] !== golden[pos+j]) ok = 0;
                chk("stream", ok, 1'b1);
            end
            if (c.mode == 2 && cyc == 29) chk("bp_full16", valid_num, 5'd16);
            case (c.mode)
                0:       take = int'(valid_num);
                1:       take = int'($urandom_range(int'(valid_num), 0));
                default: take = (cyc < 30) ? 0 : int'(valid_num);
            endcase
            pos += take;
            taken_num = 5'(take);
            @(negedge clk);
            if (c.mode == 2 && cyc == 29) chk("bp_no_req", mem_req, 1'b0);
            mem_ack = 1'b0;
            if (mem_req) begin
                if (pi >= c.n) begin
                    tests++; fails++;
                    $display("FAIL extra_req: got request %0d expected at most %0d", pi + 1, c.n);
                end else if (waitc >= c.delay) begin
                    mem_ack = 1'b1;
                    mem_data = pk[pi];
                    pi++;
                    waitc = 0;
                end else begin
                    waitc++;
                end
            end else if (waitc != 0) begin
                tests++; fails++;
                $display("FAIL req_dropped: got mem_req 0 expected 1 after %0d wait cycles", waitc);
                waitc = 0;
            end
            @(posedge clk); #1;
            mem_ack = 1'b0;
            cyc++;
        end
        taken_num = '0;
        chk("done_seen", seen_done, 1'b1);
        chk("bytes_consumed", pos, golden.size());
        chk("pkts_fetched", pi, c.n);
        chk("fmt_err", fmt_err, c.exp_err);
        chk("busy_at_done", busy, 1'b0);
        if (c.exp_peak >= 0) chk("valid_peak", peak, c.exp_peak);
        @(posedge clk); #1;
        chk("done_one_cycle", done, 1'b0);
        $display("case %0d: pkts=%0d bytes=%0d cycles=%0d fmt_err=%0b", id, c.n, pos, cyc, fmt_err);
        if (!seen_done) begin
            rst_n = 1'b0; #2; rst_n = 1'b1;
            @(posedge clk); #1;
        end
    endtask

    localparam logic [63:0] P_TWO  = {1'b1, 3'd2, 12'h000, 12'h000, 12'h000, 12'h220, 12'h112};
    localparam logic [63:0] P_TAIL = {1'b0, 3'd1, 12'h000, 12'h000, 12'h000, 12'h000, 12'hAA5};
    localparam logic [63:0] P_BIG  = {1'b1, 3'd5, 12'h05F, 12'h04F, 12'h03F, 12'h02F, 12'h01F};
    localparam logic [63:0] P_MIX  = {1'b1, 3'd3, 12'h000, 12'h000, 12'h550, 12'h444, 12'h331};
    localparam logic [63:0] P_G7   = {1'b1, 3'd7, 12'h050, 12'h040, 12'h030, 12'h020, 12'h010};
    localparam logic [63:0] P_G0   = {1'b1, 3'd0, 60'hFFF_FFFF_FFFF_FFFF};
    localparam logic [63:0] P_RST  = {1'b1, 3'd7, 12'h0C0, 12'h0C0, 12'h0C0, 12'hB23, 12'hA1F};

    case_t cases[7];
    case_t rc;
    int    wait_cnt;
    bit    got;

    initial begin
        rst_n = 1'b0; start = 1'b0; mem_ack = 1'b0; mem_data = '0;
        pkt_count = '0; taken_num = '0;

        cases[0] = '{1, P_TWO,  0,      0,     0, 0, 1'b0, 4,  3};
        cases[1] = '{1, P_TAIL, 0,      0,     0, 0, 1'b0, 5,  5};
        cases[2] = '{2, P_BIG,  P_TWO,  0,     0, 2, 1'b0, 84, 16};
        cases[3] = '{3, P_TWO,  P_TAIL, P_MIX, 4, 0, 1'b0, 17, -1};
        cases[4] = '{1, P_G7,   0,      0,     0, 0, 1'b1, 5,  -1};
        cases[5] = '{1, P_G0,   0,      0,     0, 0, 1'b0, 0,  0};
        cases[6] = '{3, P_MIX,  P_BIG,  P_TAIL,2, 1, 1'b0, 93, -1};

        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_valid", valid_num, 5'd0);
        chk("rst_data", inmap_data, 128'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_req", mem_req, 1'b0);
        chk("rst_fmt_err", fmt_err, 1'b0);

        foreach (cases[i]) run_case(i, cases[i]);

        // First-group latency: ack in N, first bytes in N+2, second group in N+3.
        start = 1'b1; pkt_count = 16'd1;
        @(posedge clk); #1; start = 1'b0;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (mem_req) got = 1;
        end
        chk("lat_req_seen", got, 1'b1);
        mem_ack = 1'b1; mem_data = P_TWO;
        @(posedge clk); #1; mem_ack = 1'b0;
        chk("lat_n1_valid", valid_num, 5'd0);
        @(posedge clk); #1;
        chk("lat_n2_valid", valid_num, 5'd3);
        chk("lat_n2_bytes", inmap_data[2:0], 24'h110000);
        @(posedge clk); #1;
        chk("lat_n3_valid", valid_num, 5'd4);
        chk("lat_n3_bytes", inmap_data[3:0], 32'h22110000);
        taken_num = 5'd4;
        @(posedge clk); #1; taken_num = '0;
        chk("lat_done", done, 1'b1);
        chk("lat_busy", busy, 1'b0);
        $display("latency seq: bytes visible two cycles after ack");

        // Zero-count start: done next cycle, busy never rises.
        start = 1'b1; pkt_count = 16'd0;
        @(posedge clk); #1; start = 1'b0;
        chk("zero_done", done, 1'b1);
        chk("zero_busy", busy, 1'b0);
        chk("zero_req", mem_req, 1'b0);
        @(posedge clk); #1;
        chk("zero_done_pulse", done, 1'b0);
        chk("zero_busy2", busy, 1'b0);
        $display("zero-count start: done pulse only");

        // Async reset while stalled at fill 20 with fmt_err set.
        start = 1'b1; pkt_count = 16'd2;
        @(posedge clk); #1; start = 1'b0;
        wait_cnt = 0;
        while (!mem_req && wait_cnt < 10) begin
            @(posedge clk); #1; wait_cnt++;
        end
        chk("rst_seq_req", mem_req, 1'b1);
        mem_ack = 1'b1; mem_data = P_RST;
        @(posedge clk); #1; mem_ack = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("stall_valid", valid_num, 5'd16);
        chk("stall_fmt_err", fmt_err, 1'b1);
        chk("stall_busy", busy, 1'b1);
        chk("stall_no_req", mem_req, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_valid", valid_num, 5'd0);
        chk("async_data", inmap_data, 128'd0);
        chk("async_busy", busy, 1'b0);
        chk("async_fmt_err", fmt_err, 1'b0);
        chk("async_req", mem_req, 1'b0);
        chk("async_done", done, 1'b0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_req", mem_req, 1'b0);
        chk("post_rst_busy", busy, 1'b0);
        $display("async reset mid-run: outputs cleared");

        // Random packets, random delays and random consumption.
        for (int r = 0; r < 15; r++) begin
            rc.n = int'($urandom_range(3, 1));
            rc.p0 = {$urandom, $urandom};
            rc.p1 = {$urandom, $urandom};
            rc.p2 = {$urandom, $urandom};
            rc.delay = int'($urandom_range(3, 0));
            rc.mode = 1;
            rc.exp_err = (rc.p0[62:60] > 3'd5) ||
                         (rc.n > 1 && rc.p1[62:60] > 3'd5) ||
                         (rc.n > 2 && rc.p2[62:60] > 3'd5);
            rc.exp_bytes = -1;
            rc.exp_peak = -1;
            run_case(100 + r, rc);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
